// File: rtl/muldiv_hilo_unit.sv
// muldiv_hilo_unit: single-cycle MULT/MULTU, iterative restoring DIV/DIVU, and the HI/LO register pair.
// A divide holds the unit busy and stalls any HI/LO access until its result is written.
module muldiv_hilo_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mul0_div1_sel,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             hilo_mov_op,
    input  logic             hi0_lo1_sel,
    output logic [WIDTH-1:0] hilo_rdata,
    output logic             busy,
    output logic             stall,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, DIV, FIX} state_t;
    state_t state, state_n;
    logic [CW-1:0] count;
    logic [WIDTH-1:0] hi, lo, rem, quo, dvs, abs_a, abs_b;
    logic neg_q, neg_r, div_zero;
    logic [2*WIDTH-1:0] ext_a, ext_b, prod;
    logic [WIDTH:0] shifted, trial;
    assign ext_a = {{WIDTH{signed_op & src_a[WIDTH-1]}}, src_a};
    assign ext_b = {{WIDTH{signed_op & src_b[WIDTH-1]}}, src_b};
    // Truncated 2W-bit product of extended operands is the exact signed or unsigned result
    assign prod = ext_a * ext_b;
    assign abs_a = (signed_op & src_a[WIDTH-1]) ? -src_a : src_a;
    assign abs_b = (signed_op & src_b[WIDTH-1]) ? -src_b : src_b;
    assign shifted = {rem, quo[WIDTH-1]};
    assign trial = shifted - {1'b0, dvs};
    assign hilo_rdata = hi0_lo1_sel ? lo : hi;
    assign stall = busy & (start | hilo_mov_op);
    always_comb begin
        state_n = state;
        state_n = (state == IDLE) ? ((start & mul0_div1_sel) ? DIV : IDLE) :
                  (state == DIV)  ? ((count == CW'(WIDTH-1)) ? FIX : DIV) : IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= '0;
            hi       <= '0;
            lo       <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state <= state_n;
            busy  <= state_n != IDLE;
            done  <= state == FIX;
            if (state == IDLE && start && !mul0_div1_sel)
                {hi, lo} <= prod;
            if (state == IDLE && start && mul0_div1_sel) begin
                rem      <= '0;
                quo      <= abs_a;
                dvs      <= abs_b;
                neg_q    <= signed_op & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                neg_r    <= signed_op & src_a[WIDTH-1];
                div_zero <= src_b == '0;
                count    <= '0;
            end
            if (state == DIV) begin
                count <= count + 1'b1;
                rem   <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                quo   <= {quo[WIDTH-2:0], ~trial[WIDTH]};
            end
            // Zero divisor leaves rem = |a|, so the dividend-sign fixup restores the original src_a
            if (state == FIX) begin
                lo <= div_zero ? '1 : (neg_q ? -quo : quo);
                hi <= neg_r ? -rem : rem;
            end
        end
    end
endmodule

// File: doc/muldiv_hilo_unit.md
Name: muldiv_hilo_unit

Overview:
- Execute-stage multiply/divide unit that consumes the ALU decoder's mul0_div1_sel, hilo_mov_op and hi0_lo1_sel outputs.
- Performs MULT/MULTU in one cycle and DIV/DIVU as an iterative restoring divider.
- Owns the architectural HI/LO registers and serves MFHI/MFLO reads.
- Raises a pipeline stall while a divide is in flight and a dependent or new HI/LO operation arrives.

Parameters:
- WIDTH, 32: operand width; HI and LO are each WIDTH bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  EX-stage instruction is MULT/MULTU/DIV/DIVU; qualified by the stall output.
- mul0_div1_sel  input  1  0 = multiply, 1 = divide.
- signed_op  input  1  1 = signed (MULT/DIV), 0 = unsigned.
- src_a  input  WIDTH  multiplicand / dividend (rs).
- src_b  input  WIDTH  multiplier / divisor (rt).
- hilo_mov_op  input  1  EX-stage instruction is MFHI/MFLO.
- hi0_lo1_sel  input  1  0 = read HI, 1 = read LO.
- hilo_rdata  output  WIDTH  combinational read of HI or LO, per hi0_lo1_sel.
- busy  output  1  registered; high while a divide is in progress.
- stall  output  1  combinational; busy & (start | hilo_mov_op).
- done  output  1  one-cycle pulse when a divide writes HI/LO.

Behaviour:
- Reset (async, rst_n low): HI=0, LO=0, state=IDLE, count=0, busy=0, done=0. Internal divider regs cleared.
- hilo_rdata is always driven from the HI/LO registers. It is 0 after reset. No internal forwarding of an in-flight result.
- FSM states: IDLE, DIV, FIX.
- IDLE, start=1, mul0_div1_sel=0:
  - At the next edge, {HI,LO} is written with the full 2*WIDTH product.
  - Signed: two's-complement product of sign-extended operands. Unsigned: zero-extended product.
  - Stays in IDLE; busy stays 0; done is not pulsed.
- IDLE, start=1, mul0_div1_sel=1, at edge E0:
  - Latch |src_a| and |src_b| (absolute values only when signed_op=1), both operand sign bits, and signed_op.
  - Clear the partial remainder; count=0; go to DIV; busy=1 from E0.
- DIV, each edge:
  - One restoring step: shift {rem,quo} left by 1, trial-subtract the divisor, keep the result if non-negative, set the quotient bit.
  - count increments. At the edge where count reaches WIDTH-1 (E32 for WIDTH=32), go to FIX.
- FIX, next edge (E33):
  - Apply signs: quotient negated if signs differ; remainder takes the dividend's sign.
  - Write LO=quotient, HI=remainder. done=1 for this one cycle. busy=0. Go to IDLE.
- Divide latency: HI/LO valid 34 edges after acceptance; busy high for 33 cycles.
- Divisor zero, either signedness: the operation still runs the full latency and writes LO=all ones and HI=the original src_a.
- Signed overflow (0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0 (wraps naturally).
- start while busy: ignored (no operand capture). stall=1 so upstream holds the instruction and re-presents it after busy falls.
- hilo_mov_op while busy: stall=1; hilo_rdata shows stale values and must not be consumed.
- In IDLE, stall=0 regardless of inputs.
- start and hilo_mov_op high together while IDLE: the multiply/divide is accepted and the read returns pre-operation HI/LO. The decoder never produces both, but the behaviour is defined.
- done and a new start in the same cycle: the FSM is in IDLE that cycle (busy=0), so the new op is accepted at that edge.
- rst_n asserted mid-divide: immediate return to IDLE; HI/LO cleared; the aborted result is never written.

Test Plan:
- Reset, then signed mult src_a=0xFFFFFFFD (-3), src_b=5 -> after one edge HI=0xFFFFFFFF, LO=0xFFFFFFF1; busy never rises. MFHI then MFLO -> hilo_rdata 0xFFFFFFFF, then 0xFFFFFFF1.
- Unsigned mult 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- Unsigned div 100/7 -> busy high 33 cycles; done pulses once at E33; LO=14, HI=2.
- Signed div -7 (0xFFFFFFF9) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Div 0x12345678/0 -> after full latency LO=0xFFFFFFFF, HI=0x12345678. During busy:
  - Assert hilo_mov_op -> stall=1, HI/LO unchanged.
  - Assert start with new operands -> stall=1 and the operands are ignored.
- Start div 1000/3, drop rst_n at cycle 10 -> busy=0, HI=LO=0 immediately. After release, no done pulse occurs.
